// File: rtl/tdm_demux_2x1.sv
// tdm_demux_2x1: receive-side 2:1 TDM demultiplexer.
// Locks to a slot-0 frame_sync marker, steers alternating beats into two
// channel output registers and tracks sync integrity with a flywheel
// (tolerate up to MISS_LIMIT-1 consecutive sync errors) before dropping lock.
module tdm_demux_2x1 #(
  parameter int DATA_W     = 8,
  parameter int MISS_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] ch0_data,
  output logic              ch0_valid,
  output logic [DATA_W-1:0] ch1_data,
  output logic              ch1_valid,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Error counter is 4 bits wide: MISS_LIMIT is bounded to 1..15.
  localparam logic [3:0] LP_MISS_LIMIT = 4'(MISS_LIMIT);

  // Frame tracking state
  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_slot;
  logic        w_slot_nxt;
  logic [3:0]  r_err_cnt;
  logic [3:0]  w_err_cnt_nxt;
  logic [3:0]  w_err_inc;
  logic        r_same_frame;
  logic        w_same_frame_nxt;
  logic        w_mismatch;

  // Output registers and their next values
  logic [DATA_W-1:0] r_ch0_data;
  logic [DATA_W-1:0] r_ch1_data;
  logic              r_ch0_valid;
  logic              r_ch1_valid;
  logic              r_frame_valid;
  logic              r_locked;
  logic              r_sync_err;
  logic [DATA_W-1:0] w_ch0_data_nxt;
  logic [DATA_W-1:0] w_ch1_data_nxt;
  logic              w_ch0_valid_nxt;
  logic              w_ch1_valid_nxt;
  logic              w_frame_valid_nxt;
  logic              w_sync_err_nxt;

  // Slot 0 expects frame_sync=1 and slot 1 expects frame_sync=0, so any
  // beat whose sync flag equals the slot index is out of place.
  assign w_mismatch = (frame_sync == r_slot);

  // Saturating increment: the counter must never wrap.
  assign w_err_inc = (r_err_cnt == 4'hF) ? 4'hF : (r_err_cnt + 4'd1);

  // Next-state and next-output decode for the HUNT/LOCKED machine.
  always_comb begin
    w_state_nxt       = r_state;
    w_slot_nxt        = r_slot;
    w_err_cnt_nxt     = r_err_cnt;
    w_same_frame_nxt  = r_same_frame;
    w_ch0_data_nxt    = r_ch0_data;
    w_ch1_data_nxt    = r_ch1_data;
    w_ch0_valid_nxt   = 1'b0;
    w_ch1_valid_nxt   = 1'b0;
    w_frame_valid_nxt = 1'b0;
    w_sync_err_nxt    = 1'b0;

    if (din_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (frame_sync) begin
            // First marker seen: this beat opens a frame on ch0.
            w_ch0_data_nxt   = din;
            w_ch0_valid_nxt  = 1'b1;
            w_same_frame_nxt = 1'b1;
            w_state_nxt      = ST_LOCKED;
            w_slot_nxt       = 1'b1;
            w_err_cnt_nxt    = 4'd0;
          end else begin
            // Unframed beat while hunting: dropped silently.
            w_state_nxt = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          if (!w_mismatch) begin
            if (!r_slot) begin
              // Clean slot-0 sync: frame start, error history cleared.
              w_ch0_data_nxt   = din;
              w_ch0_valid_nxt  = 1'b1;
              w_same_frame_nxt = 1'b1;
              w_err_cnt_nxt    = 4'd0;
              w_slot_nxt       = 1'b1;
            end else begin
              // Clean slot-1 beat closes the frame.
              w_ch1_data_nxt    = din;
              w_ch1_valid_nxt   = 1'b1;
              w_frame_valid_nxt = r_same_frame;
              w_same_frame_nxt  = 1'b0;
              w_slot_nxt        = 1'b0;
            end
          end else begin
            w_sync_err_nxt = 1'b1;
            if (w_err_inc >= LP_MISS_LIMIT) begin
              // Too many consecutive errors: drop the beat and re-hunt.
              w_state_nxt      = ST_HUNT;
              w_slot_nxt       = 1'b0;
              w_err_cnt_nxt    = 4'd0;
              w_same_frame_nxt = 1'b0;
            end else begin
              // Missing sync (flywheel) or early sync (realign): either way
              // the beat is treated as slot 0. A realign abandons the old
              // frame, so the pairing flag is cleared in that case only.
              w_ch0_data_nxt   = din;
              w_ch0_valid_nxt  = 1'b1;
              w_err_cnt_nxt    = w_err_inc;
              w_slot_nxt       = 1'b1;
              w_same_frame_nxt = ~r_slot;
            end
          end
        end

        default: begin
          w_state_nxt      = ST_HUNT;
          w_slot_nxt       = 1'b0;
          w_err_cnt_nxt    = 4'd0;
          w_same_frame_nxt = 1'b0;
        end
      endcase
    end else begin
      // Idle cycle: hold all context, pulses already defaulted low.
      w_state_nxt = r_state;
    end
  end

  // FSM state and frame context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_HUNT;
      r_slot       <= 1'b0;
      r_err_cnt    <= 4'd0;
      r_same_frame <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_same_frame <= w_same_frame_nxt;
    end
  end

  // Registered outputs, one cycle after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch0_data    <= {DATA_W{1'b0}};
      r_ch1_data    <= {DATA_W{1'b0}};
      r_ch0_valid   <= 1'b0;
      r_ch1_valid   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_ch0_data    <= w_ch0_data_nxt;
      r_ch1_data    <= w_ch1_data_nxt;
      r_ch0_valid   <= w_ch0_valid_nxt;
      r_ch1_valid   <= w_ch1_valid_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_locked      <= (w_state_nxt == ST_LOCKED);
      r_sync_err    <= w_sync_err_nxt;
    end
  end

  assign ch0_data    = r_ch0_data;
  assign ch1_data    = r_ch1_data;
  assign ch0_valid   = r_ch0_valid;
  assign ch1_valid   = r_ch1_valid;
  assign frame_valid = r_frame_valid;
  assign locked      = r_locked;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_2x1.sv
// tb_tdm_demux_2x1: directed scenarios plus a randomized run, checked
// against a beat-level reference model of the framing rules.
module tb_tdm_demux_2x1;

  localparam int DW    = 8;
  localparam int LIMIT = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          frame_sync;
  logic [DW-1:0] ch0_data;
  logic          ch0_valid;
  logic [DW-1:0] ch1_data;
  logic          ch1_valid;
  logic          frame_valid;
  logic          locked;
  logic          sync_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain per-beat framing rules.
  bit            m_locked;
  int            m_want;     // slot the next beat is expected to occupy
  int            m_misses;   // consecutive sync errors so far
  bit            m_pair;     // ch0 of the current frame already delivered
  logic [DW-1:0] m_ch0;
  logic [DW-1:0] m_ch1;
  bit            e_ch0_v, e_ch1_v, e_fv, e_err;

  tdm_demux_2x1 #(.DATA_W(DW), .MISS_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .ch0_data(ch0_data), .ch0_valid(ch0_valid),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .frame_valid(frame_valid),
    .locked(locked), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_beat(input logic [DW-1:0] d, input bit s, input bit v, input bit r);
    e_ch0_v = 0; e_ch1_v = 0; e_fv = 0; e_err = 0;
    if (r) begin
      m_locked = 0; m_want = 0; m_misses = 0; m_pair = 0; m_ch0 = '0; m_ch1 = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          e_ch0_v = 1; m_ch0 = d; m_pair = 1;
          m_locked = 1; m_want = 1; m_misses = 0;
        end
      end else if ((m_want == 0) == s) begin
        if (m_want == 0) begin
          e_ch0_v = 1; m_ch0 = d; m_pair = 1; m_misses = 0; m_want = 1;
        end else begin
          e_ch1_v = 1; m_ch1 = d; e_fv = m_pair; m_pair = 0; m_want = 0;
        end
      end else begin
        e_err = 1;
        m_misses = m_misses + 1;
        if (m_misses >= LIMIT) begin
          m_locked = 0; m_want = 0; m_misses = 0; m_pair = 0;
        end else begin
          e_ch0_v = 1; m_ch0 = d;
          m_pair = (m_want == 0);  // early sync abandons the frame
          m_want = 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input logic [DW-1:0] d, input bit s, input bit v, input bit r);
    din = d; frame_sync = s; din_valid = v; rst = r;
    model_beat(d, s, v, r);
    @(posedge clk);
    #1;
    rst = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    step(8'hFF, 1'b1, 1'b1, 1'b1);
    step(8'hFF, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({ch0_data, ch1_data} !== 16'h0000) begin
      n_errors++; $display("FAIL reset_data: got %h/%h want 00/00", ch0_data, ch1_data);
    end
    n_checks++;
    if ({ch0_valid, ch1_valid, frame_valid, locked, sync_err} !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b want 00000", {ch0_valid, ch1_valid, frame_valid, locked, sync_err});
    end
  endtask

  task automatic test_lock();
    logic [DW-1:0] d [4];
    bit            s [4];
    d = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};
    s = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(d[i], s[i], 1'b1, 1'b0);
      n_checks++;
      if (s[i] ? (ch0_valid !== 1'b1 || ch0_data !== d[i] || ch1_valid !== 1'b0)
               : (ch1_valid !== 1'b1 || ch1_data !== d[i] || frame_valid !== 1'b1 || ch0_valid !== 1'b0)) begin
        n_errors++;
        $display("FAIL lock_beat%0d: got c0v=%b c0=%h c1v=%b c1=%h fv=%b want beat %h", i,
                 ch0_valid, ch0_data, ch1_valid, ch1_data, frame_valid, d[i]);
      end
      n_checks++;
      if (locked !== 1'b1 || sync_err !== 1'b0) begin
        n_errors++; $display("FAIL lock_state%0d: got locked=%b err=%b want 1/0", i, locked, sync_err);
      end
    end
  endtask

  task automatic test_hunt_discard();
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h11, 1'b0, 1'b1, 1'b0);
    step(8'h22, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({ch0_valid, ch1_valid, locked, ch0_data} !== {3'b000, 8'h00}) begin
      n_errors++; $display("FAIL hunt_discard: got c0v=%b c1v=%b lk=%b c0=%h want 0/0/0/00",
                           ch0_valid, ch1_valid, locked, ch0_data);
    end
    step(8'h33, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ch0_valid !== 1'b1 || ch0_data !== 8'h33 || locked !== 1'b1) begin
      n_errors++; $display("FAIL hunt_lock: got c0v=%b c0=%h lk=%b want 1/33/1", ch0_valid, ch0_data, locked);
    end
    step(8'h44, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ch1_valid !== 1'b1 || ch1_data !== 8'h44 || frame_valid !== 1'b1) begin
      n_errors++; $display("FAIL hunt_ch1: got c1v=%b c1=%h fv=%b want 1/44/1", ch1_valid, ch1_data, frame_valid);
    end
  endtask

  task automatic test_gapped();
    step(8'h77, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'hEE, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({ch0_valid, ch1_valid, frame_valid, sync_err, locked} !== 5'b00001) begin
        n_errors++; $display("FAIL gap_idle%0d: got %b want 00001", i,
                             {ch0_valid, ch1_valid, frame_valid, sync_err, locked});
      end
    end
    step(8'h88, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ch1_valid !== 1'b1 || ch1_data !== 8'h88 || frame_valid !== 1'b1 || sync_err !== 1'b0) begin
      n_errors++; $display("FAIL gap_ch1: got c1v=%b c1=%h fv=%b err=%b want 1/88/1/0",
                           ch1_valid, ch1_data, frame_valid, sync_err);
    end
  endtask

  task automatic test_flywheel();
    step(8'h55, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ch0_valid !== 1'b1 || ch0_data !== 8'h55 || sync_err !== 1'b1 || locked !== 1'b1) begin
      n_errors++; $display("FAIL fly_miss: got c0v=%b c0=%h err=%b lk=%b want 1/55/1/1",
                           ch0_valid, ch0_data, sync_err, locked);
    end
    step(8'h99, 1'b0, 1'b1, 1'b0);
    step(8'h5A, 1'b1, 1'b1, 1'b0);
    step(8'h5B, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (sync_err !== 1'b0 || ch1_data !== 8'h5B || frame_valid !== 1'b1) begin
      n_errors++; $display("FAIL fly_clean: got err=%b c1=%h fv=%b want 0/5B/1", sync_err, ch1_data, frame_valid);
    end
    // Counter was cleared by the clean sync, so one new miss keeps lock.
    step(8'h5C, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ch0_valid !== 1'b1 || locked !== 1'b1 || sync_err !== 1'b1) begin
      n_errors++; $display("FAIL fly_cleared: got c0v=%b lk=%b err=%b want 1/1/1", ch0_valid, locked, sync_err);
    end
    step(8'h5D, 1'b0, 1'b1, 1'b0);
    step(8'h61, 1'b1, 1'b1, 1'b0);
    step(8'h62, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_loss_of_lock();
    step(8'h63, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (sync_err !== 1'b1 || locked !== 1'b1 || ch0_data !== 8'h63) begin
      n_errors++; $display("FAIL lol_first: got err=%b lk=%b c0=%h want 1/1/63", sync_err, locked, ch0_data);
    end
    step(8'h64, 1'b0, 1'b1, 1'b0);
    step(8'h65, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({sync_err, locked, ch0_valid, ch1_valid} !== 4'b1000 || ch0_data !== 8'h63) begin
      n_errors++; $display("FAIL lol_second: got err=%b lk=%b c0v=%b c1v=%b c0=%h want 1/0/0/0/63",
                           sync_err, locked, ch0_valid, ch1_valid, ch0_data);
    end
    step(8'h66, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (locked !== 1'b1 || ch0_valid !== 1'b1 || ch0_data !== 8'h66 || sync_err !== 1'b0) begin
      n_errors++; $display("FAIL lol_relock: got lk=%b c0v=%b c0=%h err=%b want 1/1/66/0",
                           locked, ch0_valid, ch0_data, sync_err);
    end
  endtask

  task automatic test_realign_reset();
    step(8'h67, 1'b0, 1'b1, 1'b0);
    step(8'h68, 1'b1, 1'b1, 1'b0);
    step(8'h6A, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ch0_valid !== 1'b1 || ch0_data !== 8'h6A || sync_err !== 1'b1 ||
        frame_valid !== 1'b0 || ch1_valid !== 1'b0 || locked !== 1'b1) begin
      n_errors++; $display("FAIL realign: got c0v=%b c0=%h err=%b fv=%b c1v=%b lk=%b want 1/6A/1/0/0/1",
                           ch0_valid, ch0_data, sync_err, frame_valid, ch1_valid, locked);
    end
    step(8'h6B, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({ch0_data, ch1_data} !== 16'h0000 ||
        {ch0_valid, ch1_valid, frame_valid, locked, sync_err} !== 5'b00000) begin
      n_errors++; $display("FAIL rst_midop: got c0=%h c1=%h flags=%b want 00/00/00000",
                           ch0_data, ch1_data, {ch0_valid, ch1_valid, frame_valid, locked, sync_err});
    end
    step(8'h6C, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b0 || ch0_data !== 8'h00) begin
      n_errors++; $display("FAIL rst_beat_ignored: got lk=%b c0=%h want 0/00", locked, ch0_data);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit            s, v, r;
    for (int i = 0; i < 600; i++) begin
      d = DW'($urandom);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 79) == 0);
      // Mostly well-formed framing with occasional sync errors.
      s = (m_want == 0) ^ ($urandom_range(0, 5) == 0);
      step(d, s, v, r);
      n_checks++;
      if (ch0_valid !== e_ch0_v || ch1_valid !== e_ch1_v || frame_valid !== e_fv ||
          sync_err !== e_err || locked !== m_locked || ch0_data !== m_ch0 || ch1_data !== m_ch1) begin
        n_errors++;
        $display("FAIL rand%0d: got c0v=%b c1v=%b fv=%b err=%b lk=%b c0=%h c1=%h want %b/%b/%b/%b/%b/%h/%h",
                 i, ch0_valid, ch1_valid, frame_valid, sync_err, locked, ch0_data, ch1_data,
                 e_ch0_v, e_ch1_v, e_fv, e_err, m_locked, m_ch0, m_ch1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    test_reset();
    test_lock();
    test_hunt_discard();
    test_gapped();
    test_flywheel();
    test_loss_of_lock();
    test_realign_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
